// File: rtl/pattern_seq_pkg.sv
// Shared types and constants for the pattern sequencer.
package pattern_seq_pkg;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_HOLD = 2'd2
    } state_e;

    localparam logic [7:0] WRAP_MAX = 8'd255;

endpackage

// File: rtl/pattern_seq_mem.sv
// LANES x DEPTH pattern store: single-bit write port, combinational column read.
module pattern_seq_mem #(
    parameter int                     LANES    = 4,
    parameter int                     DEPTH    = 20,
    parameter logic [LANES*DEPTH-1:0] PAT_INIT = '0,
    parameter int                     IW       = 5,
    parameter int                     LW       = 2
) (
    input  logic             i_clk,
    input  logic             i_rstn,
    input  logic             i_we,
    input  logic [LW-1:0]    i_lane,
    input  logic [IW-1:0]    i_addr,
    input  logic             i_data,
    input  logic [IW-1:0]    i_ridx,
    output logic [LANES-1:0] o_col
);

    localparam int AW = $clog2(LANES * DEPTH);

    logic [LANES*DEPTH-1:0] r_mem;
    logic [AW-1:0]          w_waddr;

    // Bit l*DEPTH+i holds lane l at step i.
    assign w_waddr = AW'(i_lane) * AW'(DEPTH) + AW'(i_addr);

    always_ff @(posedge i_clk or negedge i_rstn) begin
        if (!i_rstn) begin
            r_mem <= PAT_INIT;
        end else if (i_we) begin
            r_mem[w_waddr] <= i_data;
        end
    end

    for (genvar l = 0; l < LANES; l++) begin : g_col
        assign o_col[l] = r_mem[AW'(l * DEPTH) + AW'(i_ridx)];
    end

endmodule

// File: rtl/pattern_seq_ctrl.sv
// Plays a stored per-lane bit pattern one column per clock with start/pause/stop/loop
// sequencing; the pattern can be rewritten only while idle.
module pattern_seq_ctrl
    import pattern_seq_pkg::*;
#(
    parameter int                     LANES    = 4,
    parameter int                     DEPTH    = 20,
    parameter logic [LANES*DEPTH-1:0] PAT_INIT = '0,
    localparam int                    IW       = $clog2(DEPTH),
    localparam int                    LW       = (LANES > 1) ? $clog2(LANES) : 1
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic             start,
    input  logic             pause,
    input  logic             stop,
    input  logic             loop_en,
    input  logic             cfg_we,
    input  logic [LW-1:0]    cfg_lane,
    input  logic [IW-1:0]    cfg_addr,
    input  logic             cfg_data,
    output logic             cfg_err,
    output logic [LANES-1:0] out,
    output logic [IW-1:0]    idx,
    output logic             busy,
    output logic             done,
    output logic [7:0]       wrap_cnt
);

    state_e           r_state;
    logic             r_start;
    logic             r_done;
    logic             r_err;
    logic [IW-1:0]    r_idx;
    logic [LANES-1:0] r_out;
    logic [7:0]       r_wrap;

    logic             w_last;
    logic             w_cfg_ok;
    logic [IW-1:0]    w_ridx;
    logic [LANES-1:0] w_col;

    assign w_last   = (r_idx == IW'(DEPTH - 1));
    assign w_ridx   = (r_state == S_IDLE || w_last) ? '0 : r_idx + 1'b1;
    // A pending or coincident start counts as busy so a write never lands mid-load.
    assign w_cfg_ok = cfg_we && (r_state == S_IDLE) && !r_start && !start
                      && ({1'b0, cfg_addr} < (IW + 1)'(DEPTH))
                      && ({1'b0, cfg_lane} < (LW + 1)'(LANES));

    pattern_seq_mem #(
        .LANES    (LANES),
        .DEPTH    (DEPTH),
        .PAT_INIT (PAT_INIT),
        .IW       (IW),
        .LW       (LW)
    ) u_mem (
        .i_clk  (clk),
        .i_rstn (rstn),
        .i_we   (w_cfg_ok),
        .i_lane (cfg_lane),
        .i_addr (cfg_addr),
        .i_data (cfg_data),
        .i_ridx (w_ridx),
        .o_col  (w_col)
    );

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_state <= S_IDLE;
            r_start <= 1'b0;
            r_idx   <= '0;
            r_out   <= '0;
            r_done  <= 1'b0;
            r_err   <= 1'b0;
            r_wrap  <= '0;
        end else begin
            r_done  <= 1'b0;
            r_err   <= cfg_we && !w_cfg_ok;
            // Start is staged one cycle so column 0 appears together with busy.
            r_start <= start && !stop && (r_state == S_IDLE);
            if (stop) begin
                r_state <= S_IDLE;
                r_idx   <= '0;
                r_out   <= '0;
            end else if (r_state == S_IDLE) begin
                if (r_start) begin
                    r_state <= S_RUN;
                    r_idx   <= '0;
                    r_out   <= w_col;
                    r_wrap  <= '0;
                end
            end else if (pause) begin
                r_state <= S_HOLD;
            end else if (w_last && !loop_en) begin
                r_state <= S_IDLE;
                r_done  <= 1'b1;
            end else begin
                // Leaving HOLD advances on the same edge, so a pause costs exactly its length.
                r_state <= S_RUN;
                r_idx   <= w_ridx;
                r_out   <= w_col;
                if (w_last && r_wrap != WRAP_MAX) begin
                    r_wrap <= r_wrap + 8'd1;
                end
            end
        end
    end

    assign cfg_err  = r_err;
    assign out      = r_out;
    assign idx      = r_idx;
    assign busy     = (r_state != S_IDLE);
    assign done     = r_done;
    assign wrap_cnt = r_wrap;

endmodule

// File: tb/tb_pattern_seq_ctrl.sv
// Self-checking bench for pattern_seq_ctrl: directed scenarios plus randomized traffic
// against a cycle-level behavioural model of the playback rules.
module tb_pattern_seq_ctrl;

    localparam int LANES = 4;
    localparam int DEPTH = 20;
    localparam int IW    = 5;
    localparam int LW    = 2;
    // lane3..lane0; lane0 alternates 0,1,0,1...; lane2 step3 is 0
    localparam logic [LANES*DEPTH-1:0] PAT = 80'h12345_F0F07_3C5A1_AAAAA;

    logic             clk      = 1'b0;
    logic             rstn     = 1'b0;
    logic             start    = 1'b0;
    logic             pause    = 1'b0;
    logic             stop     = 1'b0;
    logic             loop_en  = 1'b0;
    logic             cfg_we   = 1'b0;
    logic [LW-1:0]    cfg_lane = '0;
    logic [IW-1:0]    cfg_addr = '0;
    logic             cfg_data = 1'b0;
    logic             cfg_err;
    logic [LANES-1:0] out;
    logic [IW-1:0]    idx;
    logic             busy;
    logic             done;
    logic [7:0]       wrap_cnt;

    int n_tests = 0;
    int n_fail  = 0;

    // Behavioural model state
    bit               m_mem [LANES][DEPTH];
    bit               m_busy, m_pend, m_done, m_err;
    int               m_idx, m_wrap;
    logic [LANES-1:0] m_out;

    logic [19:0] dut_vec;
    assign dut_vec = {busy, done, idx, out, wrap_cnt, cfg_err};

    pattern_seq_ctrl #(
        .LANES    (LANES),
        .DEPTH    (DEPTH),
        .PAT_INIT (PAT)
    ) dut (
        .clk      (clk),
        .rstn     (rstn),
        .start    (start),
        .pause    (pause),
        .stop     (stop),
        .loop_en  (loop_en),
        .cfg_we   (cfg_we),
        .cfg_lane (cfg_lane),
        .cfg_addr (cfg_addr),
        .cfg_data (cfg_data),
        .cfg_err  (cfg_err),
        .out      (out),
        .idx      (idx),
        .busy     (busy),
        .done     (done),
        .wrap_cnt (wrap_cnt)
    );

    always #5 clk = ~clk;

    function automatic logic [19:0] m_vec();
        return {m_busy, m_done, IW'(m_idx), m_out, 8'(m_wrap), m_err};
    endfunction

    function automatic logic [LANES-1:0] m_col(int s);
        logic [LANES-1:0] c;
        for (int l = 0; l < LANES; l++) c[l] = m_mem[l][s];
        return c;
    endfunction

    function automatic logic [LANES-1:0] pat_col(int s);
        logic [LANES*DEPTH-1:0] pv;
        logic [LANES-1:0]       c;
        pv = PAT;
        for (int l = 0; l < LANES; l++) c[l] = pv[l*DEPTH + s];
        return c;
    endfunction

    task automatic model_reset();
        logic [LANES*DEPTH-1:0] pv;
        pv = PAT;
        for (int l = 0; l < LANES; l++)
            for (int s = 0; s < DEPTH; s++) m_mem[l][s] = pv[l*DEPTH + s];
        m_busy = 0; m_pend = 0; m_done = 0; m_err = 0;
        m_idx = 0; m_wrap = 0; m_out = '0;
    endtask

    // Apply the playback rules for one clock edge using the inputs currently driven.
    task automatic model_edge();
        bit ok, pend_n;
        ok = !m_busy && !m_pend && !start && (cfg_addr < DEPTH);
        m_err = cfg_we && !ok;
        if (cfg_we && ok) m_mem[cfg_lane][cfg_addr] = cfg_data;
        pend_n = start && !stop && !m_busy;
        m_done = 0;
        if (stop) begin
            m_busy = 0; m_idx = 0; m_out = '0;
        end else if (!m_busy) begin
            if (m_pend) begin
                m_busy = 1; m_idx = 0; m_out = m_col(0); m_wrap = 0;
            end
        end else if (!pause) begin
            if (m_idx == DEPTH - 1) begin
                if (loop_en) begin
                    m_idx = 0; m_out = m_col(0);
                    if (m_wrap < 255) m_wrap++;
                end else begin
                    m_busy = 0; m_done = 1;
                end
            end else begin
                m_idx++;
                m_out = m_col(m_idx);
            end
        end
        m_pend = pend_n;
    endtask

    task automatic step();
        model_edge();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rstn = 1'b0;
        model_reset();
        repeat (3) @(posedge clk);
        #1;
        n_tests++;
        if (dut_vec !== 20'h0) begin
            n_fail++; $display("FAIL reset_state: got %h want %h", dut_vec, 20'h0);
        end
        rstn = 1'b1;
        step();
        n_tests++;
        if (dut_vec !== m_vec()) begin
            n_fail++; $display("FAIL reset_release: got %h want %h", dut_vec, m_vec());
        end
    endtask

    task automatic test_single_run();
        int nbusy = 0, ndone = 0;
        loop_en = 1'b0;
        start = 1'b1; step(); start = 1'b0;
        n_tests++;
        if (busy !== 1'b0) begin
            n_fail++; $display("FAIL single_latency: busy %b want 0", busy);
        end
        for (int k = 0; k < DEPTH + 3; k++) begin
            step();
            nbusy += int'(busy);
            ndone += int'(done);
            n_tests++;
            if (dut_vec !== m_vec()) begin
                n_fail++; $display("FAIL single_model k=%0d: got %h want %h", k, dut_vec, m_vec());
            end
            if (k < DEPTH) begin
                n_tests++;
                if (idx !== IW'(k) || out[0] !== k[0]) begin
                    n_fail++; $display("FAIL single_col k=%0d: idx %0d out0 %b want %0d %b", k, idx, out[0], k, k[0]);
                end
            end
            if (k == DEPTH) begin
                n_tests++;
                if ({busy, done, idx} !== {1'b0, 1'b1, 5'd19}) begin
                    n_fail++; $display("FAIL single_done: busy %b done %b idx %0d want 0 1 19", busy, done, idx);
                end
            end
        end
        n_tests++;
        if (nbusy != DEPTH || ndone != 1) begin
            n_fail++; $display("FAIL single_counts: busy %0d done %0d want %0d 1", nbusy, ndone, DEPTH);
        end
    endtask

    task automatic test_loop();
        int ndone = 0;
        loop_en = 1'b1;
        start = 1'b1; step(); start = 1'b0;
        for (int k = 0; k < 45; k++) begin
            step();
            ndone += int'(done);
            n_tests++;
            if (dut_vec !== m_vec() || idx !== IW'(k % DEPTH)) begin
                n_fail++; $display("FAIL loop_seq k=%0d: got %h want %h idx %0d", k, dut_vec, m_vec(), k % DEPTH);
            end
        end
        n_tests++;
        if (wrap_cnt !== 8'd2 || ndone != 0) begin
            n_fail++; $display("FAIL loop_wraps: wrap %0d done %0d want 2 0", wrap_cnt, ndone);
        end
        stop = 1'b1; step(); stop = 1'b0;
        loop_en = 1'b0;
        n_tests++;
        if (dut_vec !== m_vec() || busy !== 1'b0) begin
            n_fail++; $display("FAIL loop_stop: got %h want %h", dut_vec, m_vec());
        end
    endtask

    task automatic test_pause();
        logic [LANES-1:0] o_sv;
        int nbusy = 0;
        loop_en = 1'b0;
        start = 1'b1; step(); start = 1'b0;
        for (int k = 0; k < 6; k++) begin
            step();
            nbusy += int'(busy);
        end
        o_sv = out;
        pause = 1'b1;
        for (int k = 0; k < 3; k++) begin
            step();
            nbusy += int'(busy);
            n_tests++;
            if (idx !== 5'd5 || out !== o_sv || busy !== 1'b1) begin
                n_fail++; $display("FAIL pause_hold k=%0d: idx %0d out %h want 5 %h", k, idx, out, o_sv);
            end
        end
        pause = 1'b0;
        step();
        nbusy += int'(busy);
        n_tests++;
        if (idx !== 5'd6 || dut_vec !== m_vec()) begin
            n_fail++; $display("FAIL pause_resume: idx %0d got %h want 6 %h", idx, dut_vec, m_vec());
        end
        for (int k = 0; k < 30; k++) begin
            step();
            nbusy += int'(busy);
            n_tests++;
            if (dut_vec !== m_vec()) begin
                n_fail++; $display("FAIL pause_tail k=%0d: got %h want %h", k, dut_vec, m_vec());
            end
        end
        n_tests++;
        if (nbusy != DEPTH + 3) begin
            n_fail++; $display("FAIL pause_busy_len: got %0d want %0d", nbusy, DEPTH + 3);
        end
    endtask

    task automatic test_stop();
        loop_en = 1'b0;
        start = 1'b1; step(); start = 1'b0;
        repeat (11) step();
        n_tests++;
        if (idx !== 5'd10) begin
            n_fail++; $display("FAIL stop_pre: idx %0d want 10", idx);
        end
        stop = 1'b1; step(); stop = 1'b0;
        n_tests++;
        if ({busy, done, idx, out} !== 11'h0 || dut_vec !== m_vec()) begin
            n_fail++; $display("FAIL stop_clear: got %h want %h", dut_vec, m_vec());
        end
        start = 1'b1; step(); start = 1'b0;
        step();
        n_tests++;
        if (idx !== 5'd0 || busy !== 1'b1 || dut_vec !== m_vec()) begin
            n_fail++; $display("FAIL stop_restart: got %h want %h", dut_vec, m_vec());
        end
        stop = 1'b1; step(); stop = 1'b0;
    endtask

    task automatic test_cfg();
        loop_en = 1'b0;
        start = 1'b1; step(); start = 1'b0;
        step(); step();
        cfg_we = 1'b1; cfg_lane = 2'd2; cfg_addr = 5'd3; cfg_data = 1'b1;
        step();
        cfg_we = 1'b0;
        n_tests++;
        if (cfg_err !== 1'b1 || dut_vec !== m_vec()) begin
            n_fail++; $display("FAIL cfg_busy_err: err %b got %h want 1 %h", cfg_err, dut_vec, m_vec());
        end
        step();
        n_tests++;
        if (cfg_err !== 1'b0 || idx !== 5'd3 || out[2] !== 1'b0) begin
            n_fail++; $display("FAIL cfg_busy_nowrite: err %b idx %0d out2 %b want 0 3 0", cfg_err, idx, out[2]);
        end
        repeat (20) step();
        cfg_we = 1'b1;
        step();
        cfg_we = 1'b0;
        n_tests++;
        if (cfg_err !== 1'b0 || dut_vec !== m_vec()) begin
            n_fail++; $display("FAIL cfg_idle_ok: err %b want 0", cfg_err);
        end
        start = 1'b1; step(); start = 1'b0;
        repeat (4) step();
        n_tests++;
        if (idx !== 5'd3 || out[2] !== 1'b1 || dut_vec !== m_vec()) begin
            n_fail++; $display("FAIL cfg_visible: idx %0d out2 %b want 3 1", idx, out[2]);
        end
        repeat (20) step();
        cfg_we = 1'b1; cfg_addr = 5'd25;
        step();
        cfg_we = 1'b0;
        n_tests++;
        if (cfg_err !== 1'b1 || dut_vec !== m_vec()) begin
            n_fail++; $display("FAIL cfg_addr_range: err %b want 1", cfg_err);
        end
        cfg_we = 1'b1; cfg_addr = 5'd4; cfg_lane = 2'd1; cfg_data = ~m_mem[1][4]; start = 1'b1;
        step();
        cfg_we = 1'b0; start = 1'b0;
        n_tests++;
        if (cfg_err !== 1'b1 || dut_vec !== m_vec()) begin
            n_fail++; $display("FAIL cfg_with_start: err %b want 1", cfg_err);
        end
        step();
        stop = 1'b1; step(); stop = 1'b0;
    endtask

    task automatic test_async_reset();
        logic [LANES-1:0] c;
        loop_en = 1'b0;
        start = 1'b1; step(); start = 1'b0;
        repeat (8) step();
        n_tests++;
        if (idx !== 5'd7 || busy !== 1'b1) begin
            n_fail++; $display("FAIL areset_pre: idx %0d busy %b want 7 1", idx, busy);
        end
        #2 rstn = 1'b0;
        #1;
        n_tests++;
        if ({busy, done, idx, out, wrap_cnt} !== 19'h0) begin
            n_fail++; $display("FAIL areset_async: got %h want 0", {busy, done, idx, out, wrap_cnt});
        end
        model_reset();
        @(posedge clk);
        #1 rstn = 1'b1;
        start = 1'b1; step(); start = 1'b0;
        for (int k = 0; k < DEPTH; k++) begin
            step();
            c = pat_col(k);
            n_tests++;
            if (out !== c || wrap_cnt !== 8'd0 || dut_vec !== m_vec()) begin
                n_fail++; $display("FAIL areset_mem k=%0d: out %h want %h wrap %0d", k, out, c, wrap_cnt);
            end
        end
        repeat (3) step();
    endtask

    task automatic test_wrap_sat();
        loop_en = 1'b1;
        start = 1'b1; step(); start = 1'b0;
        for (int k = 0; k < 5140; k++) begin
            step();
            n_tests++;
            if (dut_vec !== m_vec()) begin
                n_fail++; $display("FAIL wrap_model k=%0d: got %h want %h", k, dut_vec, m_vec());
            end
        end
        n_tests++;
        if (wrap_cnt !== 8'd255) begin
            n_fail++; $display("FAIL wrap_saturate: got %0d want 255", wrap_cnt);
        end
        stop = 1'b1; step(); stop = 1'b0;
        loop_en = 1'b0;
    endtask

    task automatic test_random();
        for (int c = 0; c < 1500; c++) begin
            start    = ($urandom_range(7) == 0);
            pause    = ($urandom_range(3) == 0);
            stop     = ($urandom_range(40) == 0);
            loop_en  = 1'($urandom_range(1));
            cfg_we   = ($urandom_range(5) == 0);
            cfg_lane = LW'($urandom_range(3));
            cfg_addr = IW'($urandom_range(31));
            cfg_data = 1'($urandom_range(1));
            step();
            n_tests++;
            if (dut_vec !== m_vec()) begin
                n_fail++; $display("FAIL random c=%0d: got %h want %h", c, dut_vec, m_vec());
            end
        end
        start = 1'b0; pause = 1'b0; stop = 1'b0; cfg_we = 1'b0; loop_en = 1'b0;
    endtask

    initial begin
        test_reset();
        test_single_run();
        test_loop();
        test_pause();
        test_stop();
        test_cfg();
        test_async_reset();
        test_wrap_sat();
        test_random();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

endmodule
